lane_receiver: RTL and testbench
================================

// Module: lane_receiver
// PURPOSE
// - Receive-side counterpart of the TX lane controller.
// - Input: per-lane decoded bytes plus K-flags from the 8b/10b decoders.
// - Strips idle /K/ /R/ /A/, frames data on SCP/ECP, reassembles bytes LSB-first into AXI words.
// - Output: valid/last/keep stream to the RX AXI-Stream side.
// PARAMETERS
// LANES      4   number of lanes (lane index 0 = least significant byte)
// BYTE_W     8   decoded byte width
// DATA_W     32  output word width; DATA_W == LANES*BYTE_W
// SEL_W      2   lane_select width, $clog2(LANES)
// PORTS
// clk          in   1              system clock
// rst          in   1              asynchronous, active-high reset
// single_lane  in   1              1 = single-lane mode; 0 = all lanes striped
// lane_select  in   SEL_W          active lane in single-lane mode
// ctrl_in      in   LANES          per-lane K-character flag
// data_in      in   LANES*BYTE_W   per-lane decoded byte; lane i at [i*BYTE_W+:BYTE_W]
// m_data       out  DATA_W         reassembled word, byte 0 = first received
// m_keep       out  DATA_W/BYTE_W  byte enables, LSB-contiguous
// m_valid      out  1              one-cycle word strobe; no backpressure
// m_last       out  1              qualifies m_valid: final word of frame
// frame_err    out  1              one-cycle protocol error pulse
// BEHAVIOUR
// - Reset: all outputs 0; FSM=IDLE; staging and partial registers empty.
// - Reset mid-frame discards the frame; no m_valid is produced for it.
// - Characters (ctrl=1):
//   - Idle: K=8'hBC, R=8'h1C, A=8'h7C.
//   - SCP = 8'h5C then 8'hFB; ECP = 8'hFD then 8'hFE.
//   - Any other K value -> frame_err, FSM->IDLE, buffers flushed without output.
// - Single-lane: only lane lane_select is sampled, one byte per cycle.
//   - Data bytes fill the partial word at byte index 0..3.
// - Multi-lane: a cycle is a data cycle only when all ctrl_in=0; it yields one full word.
//   - Control cycle: SCP byte on lane 3 with lanes 0-2 carrying idle chars.
//   - Control cycle: ECP byte on lane 0 with lanes 1-3 carrying idle chars.
//   - All-idle control cycles are ignored.
//   - Any other ctrl/data mix -> frame_err, FSM->IDLE.
// - FSM:
//   - IDLE: 5C -> SCP2. Data -> frame_err pulse, stay IDLE. FD -> frame_err.
//   - SCP2: FB -> FRAME; idle char -> stay SCP2; anything else -> frame_err, IDLE.
//   - FRAME: data accumulates; idle chars ignored (clock compensation); FD -> ECP2;
//     5C -> frame_err, flush, SCP2.
//   - ECP2: FE -> end of frame, IDLE; idle char -> stay ECP2; else frame_err, flush, IDLE.
// - One-word staging (needed to mark last):
//   - When a word completes and staging is full, the staged word is emitted with
//     m_valid=1, m_last=0, m_keep=all-ones.
//   - The new word then enters staging.
//   - Outputs are registered: emitted the cycle after the completing byte/word is sampled.
// - Frame end:
//   - On FD with a non-empty partial and full staging: emit staged word, last=0.
//   - On FE with a non-empty partial: emit the partial, last=1, keep=(1<<nbytes)-1,
//     unused bytes 0.
//   - On FE with an empty partial: emit staged, last=1.
//   - Nothing staged and nothing partial (empty frame): no output, no error.
// - frame_err and m_valid may assert together only if staging emission precedes an abort;
//   on abort, staged data is dropped, so m_valid=0.
// - single_lane/lane_select are static outside IDLE.
//   - A change sampled in FRAME/SCP2/ECP2 -> frame_err, flush, IDLE.
// - Counter: byte index wraps 3->0 on word completion; partial cleared at frame end/abort.
// TESTING
// - Single lane 2, bytes 5C,FB,11,22,33,44,55,66,77,88,FD,FE (K on 5C..FB,FD,FE)
//   -> words 44332211 (last=0), then 88776655 (last=1, keep=F).
// - Single lane, SCP, 11,22,33,44,55,66, ECP -> 44332211 last=0 at FD+1;
//   00006655 last=1 keep=3 at FE+1.
// - Multi-lane, SCP cycles (lane3=5C/FB, lanes0-2=BC), data words A,B, ECP on lane0
//   -> A last=0, B last=1.
// - R/A idles (1C, 7C) interleaved mid-frame -> output identical to the no-idle case.
// - Data without SCP -> frame_err pulse, no m_valid.
// - K=8'hF7 mid-frame -> frame_err, no last.
// - rst asserted asynchronously mid-frame, then a new full frame -> only the new frame's
//   words appear, correct last/keep.

Source files
------------

// File: rtl/lane_receiver_if.sv
// Lane-side inputs and AXI-Stream-style outputs of the RX lane receiver.
// The master drives the decoded lane bytes and consumes the word stream; the slave is the receiver.
interface lane_receiver_if #(
  parameter int LANES  = 4,
  parameter int BYTE_W = 8,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 2
);
  logic                      single_lane;
  logic [SEL_W-1:0]          lane_select;
  logic [LANES-1:0]          ctrl_in;
  logic [LANES*BYTE_W-1:0]   data_in;
  logic [DATA_W-1:0]         m_data;
  logic [DATA_W/BYTE_W-1:0]  m_keep;
  logic                      m_valid;
  logic                      m_last;
  logic                      frame_err;

  modport master (
    output single_lane, lane_select, ctrl_in, data_in,
    input  m_data, m_keep, m_valid, m_last, frame_err
  );

  modport slave (
    input  single_lane, lane_select, ctrl_in, data_in,
    output m_data, m_keep, m_valid, m_last, frame_err
  );
endinterface

// File: rtl/lane_receiver.sv
// RX lane receiver: strips idle K-chars, frames on SCP/ECP and reassembles lane bytes
// LSB-first into words, holding one word back so the final word can carry m_last.
module lane_receiver #(
  parameter int LANES  = 4,
  parameter int BYTE_W = 8,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 2
) (
  input  logic           clk,
  input  logic           rst,
  lane_receiver_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_SCP2, S_FRAME, S_ECP2} state_t;
  typedef enum logic [2:0] {EV_NONE, EV_DATA, EV_SCP1, EV_SCP2, EV_ECP1, EV_ECP2, EV_BAD} ev_t;

  localparam logic [BYTE_W-1:0] K_IDLE  = BYTE_W'(8'hBC);
  localparam logic [BYTE_W-1:0] K_SKIP  = BYTE_W'(8'h1C);
  localparam logic [BYTE_W-1:0] K_ALIGN = BYTE_W'(8'h7C);
  localparam logic [BYTE_W-1:0] K_SCP1  = BYTE_W'(8'h5C);
  localparam logic [BYTE_W-1:0] K_SCP2  = BYTE_W'(8'hFB);
  localparam logic [BYTE_W-1:0] K_ECP1  = BYTE_W'(8'hFD);
  localparam logic [BYTE_W-1:0] K_ECP2  = BYTE_W'(8'hFE);

  function automatic logic is_idle(input logic [BYTE_W-1:0] b);
    return (b == K_IDLE) || (b == K_SKIP) || (b == K_ALIGN);
  endfunction

  function automatic ev_t ctrl_ev(input logic [BYTE_W-1:0] b);
    ev_t e;
    if (is_idle(b))      e = EV_NONE;
    else if (b == K_SCP1) e = EV_SCP1;
    else if (b == K_SCP2) e = EV_SCP2;
    else if (b == K_ECP1) e = EV_ECP1;
    else if (b == K_ECP2) e = EV_ECP2;
    else                  e = EV_BAD;
    return e;
  endfunction

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   part_q, part_d;
  logic [DATA_W-1:0]   stage_data_q, stage_data_d;
  logic                stage_full_q, stage_full_d;
  logic [SEL_W:0]      mode_q, mode_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [LANES-1:0]    m_keep_q, m_keep_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic                err_q, err_d;

  logic [BYTE_W-1:0]   lane_byte [LANES];
  logic [LANES-1:0]    idle_v;
  logic [BYTE_W-1:0]   sl_byte;
  logic                sl_k;
  ev_t                 ev, ev_hi, ev_lo;
  logic [DATA_W-1:0]   word;
  logic                word_done;
  logic                abort;

  // Reduce the lane inputs to one framing event per cycle.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_byte[i] = bus.data_in[i*BYTE_W +: BYTE_W];
      idle_v[i]    = bus.ctrl_in[i] && is_idle(lane_byte[i]);
    end
    sl_byte = lane_byte[bus.lane_select];
    sl_k    = bus.ctrl_in[bus.lane_select];
    ev_hi   = ctrl_ev(lane_byte[LANES-1]);
    ev_lo   = ctrl_ev(lane_byte[0]);
    ev      = EV_BAD;
    if (bus.single_lane)
      ev = sl_k ? ctrl_ev(sl_byte) : EV_DATA;
    else if (bus.ctrl_in == '0)
      ev = EV_DATA;
    else if (&idle_v)
      ev = EV_NONE;
    else if ((&idle_v[LANES-2:0]) && bus.ctrl_in[LANES-1] &&
             (ev_hi == EV_SCP1 || ev_hi == EV_SCP2))
      ev = ev_hi;
    else if ((&idle_v[LANES-1:1]) && bus.ctrl_in[0] &&
             (ev_lo == EV_ECP1 || ev_lo == EV_ECP2))
      ev = ev_lo;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    part_d       = part_q;
    stage_data_d = stage_data_q;
    stage_full_d = stage_full_q;
    mode_d       = mode_q;
    m_data_d     = '0;
    m_keep_d     = '0;
    m_valid_d    = 1'b0;
    m_last_d     = 1'b0;
    err_d        = 1'b0;
    word         = bus.data_in;
    word_done    = 1'b0;
    abort        = 1'b0;

    if (state_q == S_IDLE) mode_d = {bus.single_lane, bus.lane_select};

    if (state_q != S_IDLE && {bus.single_lane, bus.lane_select} != mode_q) begin
      err_d   = 1'b1;
      abort   = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ev == EV_SCP1)      state_d = S_SCP2;
          else if (ev != EV_NONE) err_d = 1'b1;
        end
        S_SCP2: begin
          if (ev == EV_SCP2) state_d = S_FRAME;
          else if (ev != EV_NONE) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_FRAME: begin
          case (ev)
            EV_NONE: ;
            EV_DATA: begin
              if (bus.single_lane) begin
                part_d[idx_q*BYTE_W +: BYTE_W] = sl_byte;
                if (idx_q == SEL_W'(LANES-1)) begin
                  word_done = 1'b1;
                  word      = part_d;
                  part_d    = '0;
                  idx_d     = '0;
                end else begin
                  idx_d = idx_q + 1'b1;
                end
              end else begin
                word_done = 1'b1;
              end
            end
            EV_ECP1: begin
              state_d = S_ECP2;
              // The trailing partial will carry last, so the staged word can go now.
              if (idx_q != '0 && stage_full_q) begin
                m_valid_d    = 1'b1;
                m_data_d     = stage_data_q;
                m_keep_d     = '1;
                stage_full_d = 1'b0;
              end
            end
            EV_SCP1: begin
              err_d   = 1'b1;
              abort   = 1'b1;
              state_d = S_SCP2;
            end
            default: begin
              err_d   = 1'b1;
              abort   = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_ECP2: begin
          if (ev == EV_ECP2) begin
            if (idx_q != '0) begin
              m_valid_d = 1'b1;
              m_last_d  = 1'b1;
              m_data_d  = part_q;
              for (int i = 0; i < LANES; i++) m_keep_d[i] = (i < int'(idx_q));
            end else if (stage_full_q) begin
              m_valid_d = 1'b1;
              m_last_d  = 1'b1;
              m_data_d  = stage_data_q;
              m_keep_d  = '1;
            end
            abort   = 1'b1;
            state_d = S_IDLE;
          end else if (ev != EV_NONE) begin
            err_d   = 1'b1;
            abort   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (word_done) begin
      if (stage_full_q) begin
        m_valid_d = 1'b1;
        m_data_d  = stage_data_q;
        m_keep_d  = '1;
      end
      stage_data_d = word;
      stage_full_d = 1'b1;
    end

    if (abort) begin
      idx_d        = '0;
      part_d       = '0;
      stage_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      part_q       <= '0;
      stage_full_q <= 1'b0;
      mode_q       <= '0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      part_q       <= part_d;
      stage_full_q <= stage_full_d;
      mode_q       <= mode_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      err_q        <= err_d;
    end
  end

  // Staged word content is only meaningful while stage_full_q is set.
  always_ff @(posedge clk) begin
    stage_data_q <= stage_data_d;
  end

  assign bus.m_data    = m_data_q;
  assign bus.m_keep    = m_keep_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_last    = m_last_q;
  assign bus.frame_err = err_q;
endmodule

// File: tb/tb_lane_receiver.sv
// Scoreboard bench for lane_receiver: a byte-list frame model predicts the words,
// a negedge monitor pops and compares every m_valid beat and counts frame_err pulses.
module tb_lane_receiver;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lane_receiver_if #(.LANES(4), .BYTE_W(8), .DATA_W(32), .SEL_W(2)) bus ();

  lane_receiver #(.LANES(4), .BYTE_W(8), .DATA_W(32), .SEL_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   err_seen = 0;
  int   sel      = 2;
  exp_t sbq[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) err_seen++;
    if (bus.m_valid === 1'b1) begin
      chk("sb_pending", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("m_data", bus.m_data, mon_e.data);
        chk("m_keep", 32'(bus.m_keep), 32'(mon_e.keep));
        chk("m_last", 32'(bus.m_last), 32'(mon_e.last));
      end
    end
  end

  // Frame model: group bytes into LSB-first words; only the final word is last.
  task automatic expect_frame(input bq_t bytes);
    int n, nw;
    exp_t e;
    n  = bytes.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      e = '0;
      for (int j = 0; j < 4; j++) begin
        if (w*4 + j < n) begin
          e.data[j*8 +: 8] = bytes[w*4 + j];
          e.keep[j]        = 1'b1;
        end
      end
      e.last = (w == nw - 1);
      sbq.push_back(e);
    end
  endtask

  task automatic drive(input logic k, input logic [7:0] b);
    logic [31:0] d;
    logic [3:0]  c;
    d = $urandom;
    c = 4'($urandom);
    d[sel*8 +: 8] = b;
    c[sel]        = k;
    bus.single_lane = 1'b1;
    bus.lane_select = 2'(sel);
    bus.ctrl_in     = c;
    bus.data_in     = d;
    @(posedge clk); #1;
  endtask

  task automatic drive_ml(input logic [3:0] c, input logic [31:0] d);
    bus.single_lane = 1'b0;
    bus.lane_select = 2'(sel);
    bus.ctrl_in     = c;
    bus.data_in     = d;
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic sl_frame(input string tag, input bq_t bytes, input int idle_every);
    int e0;
    e0 = err_seen;
    expect_frame(bytes);
    drive(1'b1, 8'h5C);
    if (idle_every > 0) drive(1'b1, 8'h1C);
    drive(1'b1, 8'hFB);
    foreach (bytes[i]) begin
      drive(1'b0, bytes[i]);
      if (idle_every > 0 && (i % idle_every) == idle_every - 1)
        drive(1'b1, (i % 2) ? 8'h7C : 8'h1C);
    end
    drive(1'b1, 8'hFD);
    if (idle_every > 0) drive(1'b1, 8'hBC);
    drive(1'b1, 8'hFE);
    settle();
    chk({tag, "_drained"}, 32'(sbq.size()), 32'd0);
    chk({tag, "_err"}, 32'(err_seen - e0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t bq;
    int  e0;

    bus.single_lane = 1'b1;
    bus.lane_select = 2'(sel);
    bus.ctrl_in     = 4'hF;
    bus.data_in     = 32'hBCBCBCBC;
    repeat (3) @(posedge clk);
    settle();
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_last", 32'(bus.m_last), 32'd0);
    chk("rst_m_keep", 32'(bus.m_keep), 32'd0);
    chk("rst_m_data", bus.m_data, 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b0;
    drive(1'b1, 8'hBC);

    // Eight bytes on lane 2: two full words, last on the second.
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    sl_frame("sl8", bq, 0);

    // Six bytes on lane 0: trailing partial with keep=3.
    sel = 0;
    drive(1'b1, 8'hBC);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    sl_frame("sl6", bq, 0);

    // Same eight bytes on lane 1 with R/A idles sprinkled through.
    sel = 1;
    drive(1'b1, 8'hBC);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    sl_frame("sl8_idle", bq, 3);

    // Multi-lane frame with an all-idle cycle between the two data words.
    e0 = err_seen;
    sbq.push_back('{data: 32'hA4A3A2A1, keep: 4'hF, last: 1'b0});
    sbq.push_back('{data: 32'hB4B3B2B1, keep: 4'hF, last: 1'b1});
    drive_ml(4'hF, 32'hBCBCBCBC);
    drive_ml(4'hF, 32'h5CBCBCBC);
    drive_ml(4'hF, 32'hFBBCBCBC);
    drive_ml(4'h0, 32'hA4A3A2A1);
    drive_ml(4'hF, 32'hBC7C1CBC);
    drive_ml(4'h0, 32'hB4B3B2B1);
    drive_ml(4'hF, 32'hBCBCBCFD);
    drive_ml(4'hF, 32'h1CBCBCFE);
    settle();
    chk("ml_drained", 32'(sbq.size()), 32'd0);
    chk("ml_err", 32'(err_seen - e0), 32'd0);

    // Mixed control/data lanes in multi-lane mode are an error.
    e0 = err_seen;
    drive_ml(4'b0010, 32'h1122BC44);
    drive_ml(4'hF, 32'hBCBCBCBC);
    settle();
    chk("ml_mix_err", 32'(err_seen - e0), 32'd1);

    // Data bytes without SCP: one error per byte, no words.
    sel = 3;
    e0  = err_seen;
    drive(1'b1, 8'hBC);
    drive(1'b0, 8'h11);
    drive(1'b0, 8'h22);
    drive(1'b0, 8'h33);
    drive(1'b1, 8'hBC);
    settle();
    chk("noscp_err", 32'(err_seen - e0), 32'd3);
    chk("noscp_drained", 32'(sbq.size()), 32'd0);

    // Unknown K mid-frame aborts with one word staged and a partial pending.
    e0 = err_seen;
    drive(1'b1, 8'h5C);
    drive(1'b1, 8'hFB);
    for (int i = 0; i < 6; i++) drive(1'b0, 8'(8'h21 + i));
    drive(1'b1, 8'hF7);
    drive(1'b1, 8'hBC);
    settle();
    chk("badk_err", 32'(err_seen - e0), 32'd1);
    chk("badk_drained", 32'(sbq.size()), 32'd0);
    bq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    sl_frame("after_badk", bq, 0);

    // Empty frame: no output and no error.
    e0 = err_seen;
    drive(1'b1, 8'h5C);
    drive(1'b1, 8'hFB);
    drive(1'b1, 8'hFD);
    drive(1'b1, 8'hFE);
    settle();
    chk("empty_err", 32'(err_seen - e0), 32'd0);
    chk("empty_drained", 32'(sbq.size()), 32'd0);

    // Lane select changing mid-frame aborts.
    sel = 0;
    e0  = err_seen;
    drive(1'b1, 8'hBC);
    drive(1'b1, 8'h5C);
    drive(1'b1, 8'hFB);
    drive(1'b0, 8'h31);
    drive(1'b0, 8'h32);
    sel = 1;
    drive(1'b1, 8'hBC);
    drive(1'b1, 8'hBC);
    settle();
    chk("modechg_err", 32'(err_seen - e0), 32'd1);
    chk("modechg_drained", 32'(sbq.size()), 32'd0);

    // Asynchronous reset mid-frame, then a fresh frame.
    sel = 2;
    drive(1'b1, 8'hBC);
    drive(1'b1, 8'h5C);
    drive(1'b1, 8'hFB);
    for (int i = 0; i < 5; i++) drive(1'b0, 8'(8'hE0 + i));
    #3 rst = 1'b1;
    settle();
    chk("arst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("arst_frame_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b0;
    drive(1'b1, 8'hBC);
    bq = '{8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98, 8'h99};
    sl_frame("after_rst", bq, 0);

    drive(1'b1, 8'hBC);
    settle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
